// File: rtl/nios2_system_cpu_mul_result_stage.sv
// Multiply result stage: low word in one cycle, high word via a hi x hi shift-add sequencer.
// Define NIOS2_MUL_MULX_EN to build mulxuu/mulxsu/mulxss; without it every accept completes as mul.
module nios2_system_cpu_mul_result_stage #(
    parameter int HH_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_en,
    input  logic        M_mul_start,
    input  logic [1:0]  M_mul_op,
    input  logic [31:0] M_src1,
    input  logic [31:0] M_src2,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    output logic [31:0] A_mul_result,
    output logic        A_mul_valid,
    output logic        A_mul_stall
);

    logic        accept;
    logic [15:0] mid_lo;
    logic [31:0] lo_in;

    assign accept = M_en & M_mul_start;
    // Only the low 16 bits of p2 + p3 land inside the low word.
    assign mid_lo = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
    assign lo_in  = M_mul_cell_p1 + {mid_lo, 16'h0000};

`ifdef NIOS2_MUL_MULX_EN
    localparam int         B         = HH_BITS_PER_CYCLE;
    localparam logic [4:0] LAST_STEP = 5'(16 / B - 1);

    typedef enum logic [1:0] {IDLE, HH, SUM} state_t;

    state_t      state, state_nxt;
    logic [31:0] p1_q, p2_q, p3_q, src1_q, src2_q;
    logic [1:0]  op_q;
    logic [4:0]  cnt;
    logic [31:0] acc, mcand, partial;
    logic [15:0] mplier;
    logic [32:0] p23;
    logic [63:0] full;
    logic [31:0] hi_corr;
    logic        unused_low;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && M_mul_op != 2'b00) state_nxt = HH;
            HH:      if (cnt == LAST_STEP) state_nxt = SUM;
            SUM:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplicand is pre-shifted so each step adds a B-bit slice times src1 hi.
    assign partial = mcand * {{(32 - B){1'b0}}, mplier[B-1:0]};

    assign p23        = {1'b0, p2_q} + {1'b0, p3_q};
    assign full       = {32'h0, p1_q} + {15'h0, p23, 16'h0} + {acc, 32'h0};
    assign unused_low = ^full[31:0];

    always_comb begin
        hi_corr = full[63:32];
        if (op_q[1] && src1_q[31]) hi_corr = hi_corr - src2_q;
        if (op_q == 2'b11 && src2_q[31]) hi_corr = hi_corr - src1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            A_mul_result <= '0;
            A_mul_valid  <= 1'b0;
            A_mul_stall  <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            p3_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            op_q         <= '0;
        end else begin
            A_mul_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        p1_q   <= M_mul_cell_p1;
                        p2_q   <= M_mul_cell_p2;
                        p3_q   <= M_mul_cell_p3;
                        src1_q <= M_src1;
                        src2_q <= M_src2;
                        op_q   <= M_mul_op;
                        if (M_mul_op == 2'b00) begin
                            A_mul_result <= lo_in;
                            A_mul_valid  <= 1'b1;
                        end else begin
                            A_mul_stall <= 1'b1;
                            cnt         <= '0;
                            acc         <= '0;
                            mcand       <= {16'h0000, M_src1[31:16]};
                            mplier      <= M_src2[31:16];
                        end
                    end
                end
                HH: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << B;
                    mplier <= mplier >> B;
                    cnt    <= cnt + 5'd1;
                end
                SUM: begin
                    A_mul_result <= hi_corr;
                    A_mul_valid  <= 1'b1;
                    A_mul_stall  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{M_src1, M_src2, M_mul_op, M_mul_cell_p2[31:16],
                          M_mul_cell_p3[31:16], 8'(HH_BITS_PER_CYCLE)};

    always_ff @(posedge clk) begin
        if (reset) begin
            A_mul_result <= '0;
            A_mul_valid  <= 1'b0;
        end else begin
            A_mul_valid <= accept;
            if (accept) A_mul_result <= lo_in;
        end
    end

    assign A_mul_stall = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_system_cpu_mul_result_stage.sv
// Directed bench for the multiply result stage; adapts expectations to NIOS2_MUL_MULX_EN.
module tb_nios2_system_cpu_mul_result_stage;

`ifdef NIOS2_MUL_MULX_EN
    localparam bit MULX = 1'b1;
`else
    localparam bit MULX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        M_en = 1'b0;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [1:0]  M_mul_op = '0;
    logic [31:0] M_src1 = '0, M_src2 = '0;
    logic [31:0] p1 = '0, p2 = '0, p3 = '0;
    logic [31:0] res1, res4;
    logic        vld1, vld4, stl1, stl4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nios2_system_cpu_mul_result_stage dut (
        .clk(clk), .reset(reset), .M_en(M_en), .M_mul_start(start1),
        .M_mul_op(M_mul_op), .M_src1(M_src1), .M_src2(M_src2),
        .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
        .A_mul_result(res1), .A_mul_valid(vld1), .A_mul_stall(stl1)
    );

    nios2_system_cpu_mul_result_stage #(.HH_BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .M_en(M_en), .M_mul_start(start4),
        .M_mul_op(M_mul_op), .M_src1(M_src1), .M_src2(M_src2),
        .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
        .A_mul_result(res4), .A_mul_valid(vld4), .A_mul_stall(stl4)
    );

    typedef struct {
        string       tag;
        logic [1:0]  op;
        logic [31:0] s1, s2, hi, lo;
        bit          poke, chain;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add(input string tag, input logic [1:0] op, input logic [31:0] s1, s2,
                       input logic [31:0] hi, lo, input bit poke, chain);
        vec_t v;
        v.tag = tag; v.op = op; v.s1 = s1; v.s2 = s2; v.hi = hi; v.lo = lo;
        v.poke = poke; v.chain = chain;
        vecs.push_back(v);
    endtask

    // 16x16 multiply cell feeding the stage.
    task automatic drive_ops(input logic [1:0] op, input logic [31:0] s1, s2);
        M_mul_op = op;
        M_src1   = s1;
        M_src2   = s2;
        p1 = {16'h0, s1[15:0]} * {16'h0, s2[15:0]};
        p2 = {16'h0, s1[15:0]} * {16'h0, s2[31:16]};
        p3 = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
    endtask

    // Entered and left at a falling edge.
    task automatic run_op(input vec_t v, input bit use4);
        int          n_hh, cyc, stalls, exp_lat, exp_stalls;
        bit          seen, is_x;
        logic [31:0] exp_res;
        n_hh       = use4 ? 4 : 16;
        is_x       = MULX && (v.op != 2'b00);
        exp_res    = is_x ? v.hi : v.lo;
        exp_lat    = is_x ? n_hh + 2 : 1;
        exp_stalls = is_x ? n_hh + 1 : 0;
        drive_ops(v.op, v.s1, v.s2);
        M_en = 1'b1;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        M_en = 1'b0; start1 = 1'b0; start4 = 1'b0;
        cyc = 1; stalls = 0; seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (v.poke && cyc == 3) begin
                drive_ops(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
                M_en = 1'b1;
                if (use4) start4 = 1'b1; else start1 = 1'b1;
            end else if (v.poke && cyc == 4) begin
                M_en = 1'b0; start1 = 1'b0; start4 = 1'b0;
            end
            if (use4 ? stl4 : stl1) stalls++;
            if (use4 ? vld4 : vld1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        M_en = 1'b0; start1 = 1'b0; start4 = 1'b0;
        chk({v.tag, ".res"}, use4 ? res4 : res1, exp_res);
        chk({v.tag, ".lat"}, 32'(cyc), 32'(exp_lat));
        chk({v.tag, ".stall"}, 32'(stalls), 32'(exp_stalls));
        if (!v.chain) begin
            @(negedge clk);
            chk({v.tag, ".pulse"}, {31'h0, use4 ? vld4 : vld1}, 32'h0);
            chk({v.tag, ".hold"}, use4 ? res4 : res1, exp_res);
        end
    endtask

    initial begin
        int nv;
        add("mul_a",   2'b00, 32'h0001_0003, 32'h0002_0005, 32'h0,         32'h000B_000F, 0, 0);
        add("xuu_a",   2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 32'h000B_000F, 0, 0);
        add("xuu_ff",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1);
        add("xss_ff",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0);
        add("xsu_m1",  2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
        add("xsu_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000, 0, 0);
        add("xss_min", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
        add("xss_hh",  2'b11, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0001, 32'h0000_0000, 1, 0);
        add("xuu_cy",  2'b01, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFE, 32'hFFFF_0001, 0, 0);
        add("xuu_35",  2'b01, 32'h0003_0000, 32'h0005_0000, 32'h0000_000F, 32'h0000_0000, 0, 0);
        add("mul_ff",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0000_0001, 0, 0);
        add("x4_su",   2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
        add("x4_ss",   2'b11, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0001, 32'h0000_0000, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.res",   res1, 32'h0);
        chk("rst.vld",   {31'h0, vld1}, 32'h0);
        chk("rst.stall", {31'h0, stl1}, 32'h0);
        chk("rst4.res",   res4, 32'h0);
        chk("rst4.vld",   {31'h0, vld4}, 32'h0);
        chk("rst4.stall", {31'h0, stl4}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_op(vecs[i], 1'b0);
        run_op(vecs[11], 1'b1);
        run_op(vecs[12], 1'b1);

        // Back-to-back mul: second accept on the edge that raises the first valid.
        drive_ops(2'b00, 32'h0001_0003, 32'h0002_0005);
        M_en = 1'b1; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b.res0", res1, 32'h000B_000F);
        chk("b2b.vld0", {31'h0, vld1}, 32'h1);
        drive_ops(2'b00, 32'h0000_FFFF, 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        M_en = 1'b0; start1 = 1'b0;
        chk("b2b.res1", res1, 32'hFFFF_0001);
        chk("b2b.vld1", {31'h0, vld1}, 32'h1);
        @(negedge clk);
        chk("b2b.end", {31'h0, vld1}, 32'h0);

        // Reset in the middle of an operation abandons it without a valid pulse.
        run_op(vecs[3], 1'b0);
`ifdef NIOS2_MUL_MULX_EN
        drive_ops(2'b11, 32'hFFFF_0000, 32'hFFFF_0000);
        M_en = 1'b1; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        M_en = 1'b0; start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("rmid.pre_stall", {31'h0, stl1}, 32'h1);
        reset = 1'b1;
`else
        drive_ops(2'b01, 32'h0001_0003, 32'h0002_0005);
        M_en = 1'b1; start1 = 1'b1; reset = 1'b1;
`endif
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; M_en = 1'b0; start1 = 1'b0;
        chk("rmid.stall", {31'h0, stl1}, 32'h0);
        chk("rmid.res",   res1, 32'h0);
        chk("rmid.vld",   {31'h0, vld1}, 32'h0);
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (vld1) nv++;
        end
        chk("rmid.nopulse", 32'(nv), 32'h0);
        run_op(vecs[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nios2_system_cpu_mul_result_stage.md
# nios2_system_cpu_mul_result_stage

Consumes the three registered 16x16 partial products from the CPU multiply cell together with the M-stage operands, and produces the architectural multiply result in the A stage. The low word (`mul`, `muli`) completes in one cycle. The high word (`mulxuu`, `mulxsu`, `mulxss`) needs the missing hi×hi product. A small shift-add sequencer generates it and stalls the A stage until the result is ready.

## Interface
Parameters:
- `HH_BITS_PER_CYCLE`, default 1. Multiplier bits of the hi×hi product retired per iteration cycle. Legal values are 1, 2 and 4. Iteration count N = 16 / `HH_BITS_PER_CYCLE`.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `M_en`  in  1  M-stage advance enable. This is the same enable that clocks the multiply cell.
- `M_mul_start`  in  1  the instruction in M is a multiply. Qualified by `M_en`.
- `M_mul_op`  in  2  operation code: 00 `mul`, 01 `mulxuu`, 10 `mulxsu`, 11 `mulxss`.
- `M_src1`  in  32  rA operand.
- `M_src2`  in  32  rB operand.
- `M_mul_cell_p1`  in  32  src1[15:0]×src2[15:0].
- `M_mul_cell_p2`  in  32  src1[15:0]×src2[31:16].
- `M_mul_cell_p3`  in  32  src1[31:16]×src2[15:0].
- `A_mul_result`  out  32  result word.
- `A_mul_valid`  out  1  one-cycle pulse; `A_mul_result` is valid while it is high.
- `A_mul_stall`  out  1  registered stall request to the A stage.

## Operation
- Accept condition: `M_en & M_mul_start` sampled at a rising edge while in IDLE. The accept edge latches:
  - p1, p2, p3;
  - `M_src1`, `M_src2`;
  - `M_mul_op`.
- Low word: lo = p1 + ((p2 + p3) << 16), taken mod 2^32. The sum p2 + p3 is 33 bits wide, and its carry is kept for the high word.
- Full unsigned 64-bit product: U = p1 + ((p2 + p3) << 16) + (hh << 32), where hh = src1[31:16] × src2[31:16] (32 bits).
- hh sequencer: an unsigned shift-add over src2[31:16], consuming `HH_BITS_PER_CYCLE` bits per cycle, LSB first, for N cycles.
- Signed correction is applied to the high word uhi = U[63:32], mod 2^32:
  - `mulxuu`: uhi.
  - `mulxsu` (rA signed, rB unsigned): uhi − (src1[31] ? src2 : 0).
  - `mulxss`: uhi − (src1[31] ? src2 : 0) − (src2[31] ? src1 : 0).
- FSM states:
  - IDLE:
    - accept with op 00 → stay in IDLE; `A_mul_result` ← lo and `A_mul_valid` ← 1.
    - accept with op ≠ 00 → HH; iteration counter ← 0, accumulator ← 0, `A_mul_stall` ← 1.
  - HH: one step per cycle. After N steps → SUM.
  - SUM: form U and apply the correction → IDLE. On that edge, `A_mul_result` ← corrected high word, `A_mul_valid` ← 1, `A_mul_stall` ← 0.
- `M_mul_start` outside IDLE is ignored. The core guarantees `M_en` = 0 while `A_mul_stall` = 1; the bench checks that a start in this window does not corrupt the result.
- `A_mul_result` holds its last value until the next completion.

## Timing
- Reset: state = IDLE, `A_mul_result` = 0, `A_mul_valid` = 0, `A_mul_stall` = 0, counter and accumulator = 0.
- Reset asserted mid-operation:
  - Takes effect on the next edge and abandons the operation.
  - No `A_mul_valid` pulse is produced.
- `mul` latency:
  - Accept edge E0.
  - `A_mul_valid` = 1 during the cycle after E0.
  - `A_mul_stall` stays 0 throughout.
- `mulx*` latency (E1 is the first edge after E0, counting onward):
  - `A_mul_stall` = 1 from after E0 through the cycle before E(N+1); that is N+1 cycles (17 at the default).
  - `A_mul_valid` = 1 for exactly one cycle, after E(N+1).
- Back-to-back:
  - A new accept is legal on the same edge that sets `A_mul_valid` for `mul`.
  - After a `mulx*`, a new accept is legal on the edge immediately following the SUM edge.
- `A_mul_valid` is never high on two consecutive cycles for the same accept.

## Configuration
- `NIOS2_MUL_MULX_EN` defined:
  - Full behaviour as above.
- `NIOS2_MUL_MULX_EN` undefined:
  - The hh sequencer, the HH and SUM states, and the operand latches are not built.
  - Every accept completes as `mul`: lo in one cycle, whatever `M_mul_op` is.
  - `A_mul_stall` is tied to 0.

## Test plan
- `mul` with src1 = 0x0001_0003, src2 = 0x0002_0005 (p1 = 15, p2 = 6, p3 = 5) → one cycle later `A_mul_result` = 0x000B_000F, valid pulse, no stall.
- `mulxuu` with the same operands → stall for 17 cycles, then `A_mul_result` = 0x0000_0002 with a single valid pulse.
- `mulxuu` with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFF_FFFE. `mulxss` with the same operands → 0x0000_0000.
- `mulxsu` with src1 = 0xFFFFFFFF, src2 = 0x0000_0002 → 0xFFFF_FFFF. Run the same case with `HH_BITS_PER_CYCLE` = 4 → stall for 5 cycles, same result.
- `mulxss` started, `reset` pulsed in the 5th HH cycle → next cycle `A_mul_stall` = 0 and `A_mul_result` = 0; no valid pulse follows; a subsequent `mul` completes normally.
- Build without `NIOS2_MUL_MULX_EN`, issue `mulxuu` with the operands of scenario 1 → one-cycle result 0x000B_000F, stall never asserted.
